// File: rtl/mips_dmem_responder.sv
// Data-memory responder for a MIPS core: word RAM with byte-lane writes,
// a free-running cycle counter and a byte-wide TX FIFO behind an MMIO window.
module mips_dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  mem_write_en,
   input  logic        mem_read_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [15:0] {
      MMIO_CYCLES = 16'h0000,
      MMIO_TXDATA = 16'h0004,
      MMIO_STATUS = 16'h0008
   } mmio_reg_e;

   // storage
   logic [31:0]      ram [0:(1 << ADDR_WIDTH) - 1];
   logic [7:0]       fifo_mem [0:FIFO_DEPTH - 1];

   // state
   logic [31:0]      cycles;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             ovf;

   // decode / control
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic [15:0]      mmio_off;
   logic             is_mmio;
   logic             wr_any;
   logic             ram_wr;
   logic             push;
   logic             push_ok;
   logic             pop;
   logic             ovf_set;
   logic             status_wr;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] occ_mod;
   logic [31:0]      occ32;
   logic [2:0]       cnt_field;
   logic [31:0]      status_word;
   logic [31:0]      rd_word;

   // Address decode and access strobes for the current cycle.
   always_comb begin
      ram_idx   = mem_addr[ADDR_WIDTH+1:2];
      mmio_off  = mem_addr[15:0];
      is_mmio   = (mem_addr[31:16] == 16'hFFFF);
      wr_any    = en && (mem_write_en != 4'b0000);
      ram_wr    = wr_any && !is_mmio && !rst;
      push      = wr_any && is_mmio && (mmio_off == MMIO_TXDATA);
      status_wr = wr_any && is_mmio && (mmio_off == MMIO_STATUS);
   end

   // FIFO flags and push/pop arbitration; a pop frees the slot a full push needs.
   always_comb begin
      fifo_full  = (count == DEPTH_C);
      fifo_empty = (count == '0);
      pop        = tx_valid && tx_ready;
      push_ok    = push && (!fifo_full || pop);
      ovf_set    = push && fifo_full && !pop;
   end

   // STATUS word; the count field shows occupancy modulo the depth (full is
   // reported by its own flag), saturated to what fits in three bits.
   always_comb begin
      occ_mod     = fifo_full ? '0 : count;
      occ32       = 32'(occ_mod);
      cnt_field   = (occ32 > 32'd7) ? 3'd7 : occ32[2:0];
      status_word = {26'b0, ovf, cnt_field, fifo_empty, fifo_full};
   end

   // Read mux: RAM word or MMIO register, sampled pre-edge (read-first).
   always_comb begin
      rd_word = '0;
      if (is_mmio) begin
         case (mmio_off)
            MMIO_CYCLES: rd_word = cycles;
            MMIO_STATUS: rd_word = status_word;
            default:     rd_word = '0;
         endcase
      end else begin
         rd_word = ram[ram_idx];
      end
   end

   // Head of the FIFO is presented combinationally.
   always_comb begin
      tx_valid = !fifo_empty;
      tx_data  = fifo_mem[rd_ptr];
   end

   // RAM byte-lane writes; bit 3 of the enable maps to bits 31:24.
   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (mem_write_en[i]) begin
               ram[ram_idx][i*8 +: 8] <= mem_write_data[i*8 +: 8];
            end
         end
      end
   end

   // Registered read data, updated only on an enabled read.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_read_data <= '0;
      end else if (en && mem_read_en) begin
         mem_read_data <= rd_word;
      end
   end

   // Free-running cycle counter, advancing on enabled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycles <= '0;
      end else if (en) begin
         cycles <= cycles + 32'd1;
      end
   end

   // FIFO byte storage; contents are not reset, pointers make them invisible.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         fifo_mem[wr_ptr] <= mem_write_data[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_ok && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push_ok) begin
            count <= count - CNT_W'(1);
         end
         if (status_wr) begin
            ovf <= 1'b0;
         end else if (ovf_set) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed and randomized checks of mips_dmem_responder against a queue-based model.
module tb_mips_dmem_responder;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  mem_write_en;
   logic        mem_read_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_ram [int unsigned];
   logic [7:0]  m_q [$];
   logic [31:0] m_cyc;
   logic [31:0] m_rd;
   logic        m_ovf;

   mips_dmem_responder #(
      .ADDR_WIDTH(AW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .mem_write_en  (mem_write_en),
      .mem_read_en   (mem_read_en),
      .mem_addr      (mem_addr),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      int occ;
      int f;
      logic [2:0] f3;
      occ = m_q.size();
      f   = occ % DEPTH;
      if (f > 7) f = 7;
      f3 = f[2:0];
      return {26'b0, m_ovf, f3, (occ == 0), (occ == DEPTH)};
   endfunction

   // One clock of the specified behaviour, using pre-edge model state.
   task automatic m_step(input logic r, input logic e, input logic [3:0] we, input logic re,
                         input logic [31:0] a, input logic [31:0] wd, input logic rdy);
      bit          mmio;
      bit          pop;
      bit          full;
      int unsigned idx;
      logic [15:0] off;
      logic [31:0] w;
      if (r) begin
         m_rd  = 0;
         m_cyc = 0;
         m_q.delete();
         m_ovf = 0;
         return;
      end
      mmio = (a[31:16] == 16'hFFFF);
      off  = a[15:0];
      idx  = int'(a[AW+1:2]);
      pop  = (m_q.size() != 0) && rdy;
      full = (m_q.size() == DEPTH);
      if (e && re) begin
         if (mmio) m_rd = (off == 16'h0000) ? m_cyc : (off == 16'h0008) ? m_status() : 32'h0;
         else      m_rd = m_ram.exists(idx) ? m_ram[idx] : 32'hxxxxxxxx;
      end
      if (pop) void'(m_q.pop_front());
      if (e && we != 4'b0000) begin
         if (!mmio) begin
            w = m_ram.exists(idx) ? m_ram[idx] : 32'hxxxxxxxx;
            for (int i = 0; i < 4; i++) if (we[i]) w[i*8 +: 8] = wd[i*8 +: 8];
            m_ram[idx] = w;
         end else if (off == 16'h0004) begin
            if (!full || pop) m_q.push_back(wd[7:0]);
            else              m_ovf = 1;
         end else if (off == 16'h0008) begin
            m_ovf = 0;
         end
      end
      if (e) m_cyc = m_cyc + 32'd1;
   endtask

   // Drive one cycle, advance the model, check visible outputs after the edge.
   task automatic cyc(input logic r, input logic e, input logic [3:0] we, input logic re,
                      input logic [31:0] a, input logic [31:0] wd, input logic rdy);
      rst = r; en = e; mem_write_en = we; mem_read_en = re;
      mem_addr = a; mem_write_data = wd; tx_ready = rdy;
      m_step(r, e, we, re, a, wd, rdy);
      @(posedge clk);
      #1;
      chk("rdata", mem_read_data, m_rd);
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d, input logic rdy);
      cyc(1'b0, 1'b1, we, 1'b0, a, d, rdy);
   endtask

   task automatic rd(input logic [31:0] a, input logic rdy);
      cyc(1'b0, 1'b1, 4'b0000, 1'b1, a, 32'h0, rdy);
   endtask

   task automatic idle(input logic e, input logic rdy);
      cyc(1'b0, e, 4'b0000, 1'b0, 32'h0, 32'h0, rdy);
   endtask

   initial begin
      logic [31:0] pool [9];
      logic [7:0]  last;
      pool = '{32'h10, 32'h14, 32'h20, 32'h24, 32'h1010,
               32'hFFFF0000, 32'hFFFF0004, 32'hFFFF0008, 32'hFFFF000C};
      m_cyc = 0; m_rd = 0; m_ovf = 0;
      rst = 1; en = 0; mem_write_en = 0; mem_read_en = 0;
      mem_addr = 0; mem_write_data = 0; tx_ready = 0;

      // reset, with en and tx_ready asserted to show reset wins
      cyc(1'b1, 1'b1, 4'b0000, 1'b1, 32'h0, 32'h0, 1'b1);
      cyc(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("reset_rdata", mem_read_data, 32'h0);
      chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);

      // cycle counter and enable gating
      repeat (5) idle(1'b1, 1'b0);
      repeat (3) idle(1'b0, 1'b0);
      rd(32'hFFFF0000, 1'b0);
      chk("cycles_5", mem_read_data, 32'd5);
      wr(32'hFFFF0000, 4'hF, 32'h1234, 1'b0);
      rd(32'hFFFF0000, 1'b0);
      chk("cycles_write_ignored", mem_read_data, 32'd7);

      // byte lanes
      wr(32'h10, 4'hF, 32'h11223344, 1'b0);
      wr(32'h12, 4'b0010, 32'hAAAAAAAA, 1'b0);
      rd(32'h10, 1'b0);
      chk("byte_lane", mem_read_data, 32'h1122AA44);

      // read-first on same word
      wr(32'h20, 4'hF, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 4'hF, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0);
      chk("read_first_old", mem_read_data, 32'h0);
      rd(32'h20, 1'b0);
      chk("read_first_new", mem_read_data, 32'hDEADBEEF);

      // unmapped MMIO and TXDATA read as zero
      rd(32'hFFFF000C, 1'b0);
      chk("unmapped_rd", mem_read_data, 32'h0);
      rd(32'hFFFF0004, 1'b0);
      chk("txdata_rd", mem_read_data, 32'h0);

      // FIFO full and overflow
      for (int i = 0; i < 5; i++) wr(32'hFFFF0004, 4'b0001, 32'h41 + i, 1'b0);
      rd(32'hFFFF0008, 1'b0);
      chk("status_ovf_full", mem_read_data, 32'h21);
      for (int i = 0; i < 4; i++) begin
         chk("pop_order", {24'b0, tx_data}, 32'h41 + i);
         idle(1'b0, 1'b1);
      end
      chk("drained", {31'b0, tx_valid}, 32'h0);
      wr(32'hFFFF0008, 4'hF, 32'h0, 1'b0);
      rd(32'hFFFF0008, 1'b0);
      chk("ovf_cleared", mem_read_data, 32'h02);

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++) wr(32'hFFFF0004, 4'b0001, 32'h41 + i, 1'b0);
      wr(32'hFFFF0004, 4'b0001, 32'h55, 1'b1);
      chk("push_pop_head", {24'b0, tx_data}, 32'h42);
      rd(32'hFFFF0008, 1'b0);
      chk("push_pop_status", mem_read_data, 32'h01);
      last = 8'h00;
      for (int i = 0; i < 10; i++) begin
         if (!tx_valid) break;
         last = tx_data;
         idle(1'b0, 1'b1);
      end
      chk("push_pop_last", {24'b0, last}, 32'h55);

      // reset mid-operation
      wr(32'h10, 4'hF, 32'h12345678, 1'b0);
      for (int i = 0; i < 3; i++) wr(32'hFFFF0004, 4'b0001, 32'h60 + i, 1'b0);
      rd(32'h10, 1'b0);
      chk("pre_rst_rdata", mem_read_data, 32'h12345678);
      cyc(1'b1, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("rst_rdata", mem_read_data, 32'h0);
      rd(32'h10, 1'b0);
      chk("ram_kept", mem_read_data, 32'h12345678);
      wr(32'hFFFF0004, 4'b0001, 32'h77, 1'b0);
      chk("post_rst_head", {24'b0, tx_data}, 32'h77);
      idle(1'b0, 1'b1);

      // initialise remaining RAM words of the random pool
      wr(32'h14, 4'hF, 32'hCAFEF00D, 1'b0);
      wr(32'h24, 4'hF, 32'h0BADC0DE, 1'b0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic        r;
         logic        e;
         logic [3:0]  we;
         logic        re;
         logic [31:0] a;
         r  = ($urandom_range(0, 59) == 0);
         e  = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         re = 1'($urandom_range(0, 1));
         a  = pool[$urandom_range(0, 8)];
         cyc(r, e, we, re, a, $urandom(), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
